// File: rtl/bcd_pkg.sv
// bcd_pkg -- shared BCD helpers for the clock-field counters.
//   BCD_DIGIT_W : width of one BCD digit (4).
//   dec_to_bcd  : elaboration-time decimal -> packed BCD conversion.
//   bcd_valid   : 1 when every nibble of the vector is 0..9.
// Vectors are carried as a fixed 16-digit container; callers zero-extend
// or slice to their own width.
package bcd_pkg;

    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_MAX_DIGITS = 16;

    typedef logic [BCD_DIGIT_W*BCD_MAX_DIGITS-1:0] bcd_vec_t;

    function automatic bcd_vec_t dec_to_bcd(input int value, input int digits);
        bcd_vec_t r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            if (i < digits) begin
                r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction

    // Zero nibbles are valid, so a zero-extended narrower vector checks cleanly.
    function automatic logic bcd_valid(input bcd_vec_t vec);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            if (vec[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit -- one combinational BCD digit cell of the counter chain.
//   d      in  4  current digit (may be non-BCD after an unchecked load)
//   inc_in in  1  increment this digit (carry from the lower digit)
//   dec_in in  1  decrement this digit (borrow from the lower digit)
//   norm   out 4  digit with any non-BCD value clamped to 9
//   q      out 4  stepped digit (norm when neither inc_in nor dec_in)
//   co     out 1  carry out: incremented past 9
//   bo     out 1  borrow out: decremented past 0
// inc_in and dec_in are never asserted together by the top level.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    input  logic                   inc_in,
    input  logic                   dec_in,
    output logic [BCD_DIGIT_W-1:0] norm,
    output logic [BCD_DIGIT_W-1:0] q,
    output logic                   co,
    output logic                   bo
);

    always_comb begin
        // A non-BCD digit steps as if it held 9.
        norm = (d > 4'd9) ? 4'd9 : d;
        q    = norm;
        co   = 1'b0;
        bo   = 1'b0;
        if (inc_in) begin
            if (norm == 4'd9) begin
                q  = 4'd0;
                co = 1'b1;
            end else begin
                q = norm + 4'd1;
            end
        end else if (dec_in) begin
            if (norm == 4'd0) begin
                q  = 4'd9;
                bo = 1'b1;
            end else begin
                q = norm - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter -- N-digit BCD up/down counter with programmable modulus
// [MIN_VAL, MAX_VAL], RTC load path and chainable carry/borrow pulses.
// Optional load range/BCD checker: define BCD_COUNTER_LOAD_CHECK_EN.
// Ports:
//   clk      in  1         clock, rising edge
//   reset    in  1         synchronous active-high reset (out <- MIN_VAL)
//   enable   in  1         0 = load dato_rtc every cycle, 1 = count
//   dato_rtc in  4*DIGITS  BCD load value
//   up/down  in  1         user step requests
//   tick     in  1         timekeeping increment (prescaler or prior carry)
//   out      out 4*DIGITS  registered BCD count
//   carry    out 1         pulse: wrapped MAX_VAL -> MIN_VAL on increment
//   borrow   out 1         pulse: wrapped MIN_VAL -> MAX_VAL on decrement
//   load_err out 1         pulse: load rejected (checker builds only)
module bcd_mod_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 23
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] dato_rtc,
    input  logic                          up,
    input  logic                          down,
    input  logic                          tick,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out,
    output logic                          carry,
    output logic                          borrow,
    output logic                          load_err
);

    localparam int W = BCD_DIGIT_W * DIGITS;

    // Packed BCD compares order the same as the decimal values they encode.
    localparam logic [W-1:0] MIN_BCD = W'(dec_to_bcd(MIN_VAL, DIGITS));
    localparam logic [W-1:0] MAX_BCD = W'(dec_to_bcd(MAX_VAL, DIGITS));

    logic inc, dec;
    assign inc = (up | tick) & ~down;
    assign dec = down & ~up & ~tick;

    logic [DIGITS-1:0][BCD_DIGIT_W-1:0] cur, norm, stepped;
    logic [DIGITS:0]                    cin, bin;

    assign cur    = out;
    assign cin[0] = inc;
    assign bin[0] = dec;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .d      (cur[g]),
                .inc_in (cin[g]),
                .dec_in (bin[g]),
                .norm   (norm[g]),
                .q      (stepped[g]),
                .co     (cin[g+1]),
                .bo     (bin[g+1])
            );
        end
    endgenerate

    logic [W-1:0] norm_v, step_v;
    assign norm_v = norm;
    assign step_v = stepped;

    // Whole-value wrap decisions. The >=/<= forms also catch out-of-range
    // values left by an unchecked load; the chain overflow terms only matter
    // if the modulus spans the full digit range.
    logic wrap_inc, wrap_dec;
    assign wrap_inc = (norm_v >= MAX_BCD) | cin[DIGITS];
    assign wrap_dec = (norm_v <= MIN_BCD) | bin[DIGITS];

    logic load_bad;
`ifdef BCD_COUNTER_LOAD_CHECK_EN
    assign load_bad = !bcd_valid(bcd_vec_t'(dato_rtc))
                    || (dato_rtc < MIN_BCD) || (dato_rtc > MAX_BCD);
`else
    assign load_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out      <= MIN_BCD;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end else if (!enable) begin
            carry    <= 1'b0;
            borrow   <= 1'b0;
            load_err <= load_bad;
            if (!load_bad) out <= dato_rtc;
        end else begin
            carry    <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
            if (inc) begin
                if (wrap_inc) begin
                    out   <= MIN_BCD;
                    carry <= 1'b1;
                end else begin
                    out <= step_v;
                end
            end else if (dec) begin
                if (wrap_dec) begin
                    out    <= MAX_BCD;
                    borrow <= 1'b1;
                end else begin
                    out <= step_v;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench for bcd_mod_counter: two instances (0..23 and 1..12) share
// stimulus. The driver runs a decimal reference model and queues the expected
// post-edge state; the monitor pops and compares one entry per clock.
module tb_bcd_mod_counter;

    logic       clk = 1'b0;
    logic       reset, enable, up, down, tick;
    logic [7:0] dato_rtc;
    logic [7:0] out0, out1;
    logic       carry0, borrow0, err0, carry1, borrow1, err1;

    always #5 clk = ~clk;

    bcd_mod_counter #(.DIGITS(2), .MIN_VAL(0), .MAX_VAL(23)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .dato_rtc(dato_rtc),
        .up(up), .down(down), .tick(tick),
        .out(out0), .carry(carry0), .borrow(borrow0), .load_err(err0));

    bcd_mod_counter #(.DIGITS(2), .MIN_VAL(1), .MAX_VAL(12)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .dato_rtc(dato_rtc),
        .up(up), .down(down), .tick(tick),
        .out(out1), .carry(carry1), .borrow(borrow1), .load_err(err1));

    typedef struct {
        logic [7:0] o0, o1;
        logic       c0, b0, e0, c1, b1, e1;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   v0 = 0;
    int   v1 = 1;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    // Decimal-value model of one field.
    task automatic model(inout int v, input int mn, input int mx,
                         input logic r, input logic en, input logic [7:0] d,
                         input logic u, input logic dn, input logic t,
                         output logic c, output logic b, output logic e);
        int dv;
        c = 1'b0; b = 1'b0; e = 1'b0;
        dv = int'(d[7:4]) * 10 + int'(d[3:0]);
        if (r) begin
            v = mn;
        end else if (!en) begin
`ifdef BCD_COUNTER_LOAD_CHECK_EN
            if (dv < mn || dv > mx) e = 1'b1;
            else v = dv;
`else
            v = dv;
`endif
        end else if ((u || t) && !dn) begin
            if (v >= mx) begin v = mn; c = 1'b1; end
            else v = v + 1;
        end else if (dn && !u && !t) begin
            if (v <= mn) begin v = mx; b = 1'b1; end
            else v = v - 1;
        end
    endtask

    // Apply one cycle of stimulus (called just after a falling edge).
    task automatic step(input logic r, input logic en, input logic [7:0] d,
                        input logic u, input logic dn, input logic t);
        exp_t x;
        model(v0, 0, 23, r, en, d, u, dn, t, x.c0, x.b0, x.e0);
        model(v1, 1, 12, r, en, d, u, dn, t, x.c1, x.b1, x.e1);
        x.o0 = to_bcd(v0);
        x.o1 = to_bcd(v1);
        exp_q.push_back(x);
        reset = r; enable = en; dato_rtc = d; up = u; down = dn; tick = t;
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: outputs are registered, so every clock presents a new result.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t x;
                x = exp_q.pop_front();
                check("out_0_23",    out0,           x.o0);
                check("carry_0_23",  {7'd0, carry0},  {7'd0, x.c0});
                check("borrow_0_23", {7'd0, borrow0}, {7'd0, x.b0});
                check("lderr_0_23",  {7'd0, err0},    {7'd0, x.e0});
                check("out_1_12",    out1,           x.o1);
                check("carry_1_12",  {7'd0, carry1},  {7'd0, x.c1});
                check("borrow_1_12", {7'd0, borrow1}, {7'd0, x.b1});
                check("lderr_1_12",  {7'd0, err1},    {7'd0, x.e1});
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b1; dato_rtc = 8'h00; up = 1'b0; down = 1'b0; tick = 1'b0;
        @(negedge clk);
        step(1, 1, 8'h00, 0, 0, 0);
        step(1, 1, 8'h00, 1, 0, 0);                 // reset beats up
        for (int i = 0; i < 24; i++) step(0, 1, 8'h00, 1, 0, 0);   // 01..23,00
        step(0, 1, 8'h00, 0, 1, 0);                 // 00 -> 23 borrow
        step(0, 0, 8'h10, 0, 0, 0);                 // load 10
        step(0, 1, 8'h00, 0, 1, 0);                 // 10 -> 09
        step(0, 0, 8'h01, 0, 0, 0);
        step(0, 1, 8'h00, 0, 1, 0);                 // 01 -> 12 borrow (1..12)
        step(0, 0, 8'h12, 0, 0, 0);
        step(0, 1, 8'h00, 0, 0, 1);                 // 12 -> 01 carry (1..12)
        step(0, 0, 8'h15, 0, 0, 0);
        step(0, 1, 8'h00, 1, 1, 0);                 // up&down hold
        step(0, 1, 8'h00, 0, 1, 1);                 // tick&down hold
        step(0, 1, 8'h00, 1, 0, 1);                 // tick&up single step
        step(0, 0, 8'h45, 0, 0, 0);                 // out-of-range load
        step(0, 0, 8'h45, 0, 0, 0);                 // repeated bad load
        step(0, 1, 8'h00, 1, 0, 0);                 // 45 -> 00 carry if loaded
        step(0, 0, 8'h16, 0, 0, 0);
        step(0, 1, 8'h00, 1, 0, 0);                 // 17
        step(1, 1, 8'h00, 1, 0, 0);                 // reset mid-count
        step(0, 1, 8'h00, 1, 0, 0);                 // 01
        step(0, 1, 8'h00, 1, 0, 0);                 // 02
        for (int i = 0; i < 400; i++) begin
            logic       r, en, u, dn, t;
            logic [7:0] d;
            r  = ($urandom_range(0, 49) == 0);
            en = ($urandom_range(0, 9) != 0);
            d  = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            u  = 1'($urandom);
            dn = 1'($urandom);
            t  = 1'($urandom);
            step(r, en, d, u, dn, t);
        end
        step(0, 1, 8'h00, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
